// File: rtl/radio_watchdog_timer_pkg.sv
// Shared constants for the host-link watchdog.
package radio_watchdog_timer_pkg;

  localparam int unsigned CNT_W = 32;

  // Default thresholds for a 125 MHz system clock: 5 s trigger, 4 s warning.
  localparam longint unsigned WD_TIMEOUT_DEFAULT = 64'd625_000_000;
  localparam longint unsigned WD_WARNING_DEFAULT = 64'd500_000_000;

  // Largest count the 32-bit counter can represent.
  localparam longint unsigned WD_CNT_MAX = 64'h0000_0000_FFFF_FFFF;

endpackage : radio_watchdog_timer_pkg

// File: rtl/radio_watchdog_timer.sv
// Host-link watchdog: counts cycles since the last heartbeat, raises a warning
// past a threshold and latches a sticky trigger on timeout.
module radio_watchdog_timer
  import radio_watchdog_timer_pkg::*;
#(
  parameter longint unsigned TIMEOUT_CYCLES = WD_TIMEOUT_DEFAULT,
  parameter longint unsigned WARNING_CYCLES = WD_WARNING_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             heartbeat,
  input  logic             force_reset,
  output logic [CNT_W-1:0] counter,
  output logic             warning,
  output logic             triggered
);

  // Reject illegal threshold combinations at elaboration.
  if (WARNING_CYCLES == 64'd0 || WARNING_CYCLES >= TIMEOUT_CYCLES ||
      TIMEOUT_CYCLES > WD_CNT_MAX) begin : g_bad_params
    $error("radio_watchdog_timer: require 0 < WARNING_CYCLES < TIMEOUT_CYCLES <= 2^32-1");
  end

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] WARNING_C = CNT_W'(WARNING_CYCLES);

  logic [CNT_W-1:0] counter_q, counter_d;
  logic             warning_q, warning_d;
  logic             triggered_q, triggered_d;
  logic [CNT_W-1:0] count_inc;

  // Next-state logic, priority order: force_reset, disable, trigger hold, heartbeat, count.
  always_comb begin
    counter_d   = counter_q;
    warning_d   = warning_q;
    triggered_d = triggered_q;
    // Cannot wrap: counting stops once the counter saturates at TIMEOUT_C.
    count_inc   = counter_q + CNT_W'(1);

    if (force_reset) begin
      counter_d   = '0;
      warning_d   = 1'b0;
      triggered_d = 1'b0;
    end else if (!enable) begin
      counter_d = '0;
      warning_d = 1'b0;
    end else if (triggered_q) begin
      // Timed out: everything holds until force_reset or reset.
    end else if (heartbeat) begin
      counter_d = '0;
      warning_d = 1'b0;
    end else if (count_inc >= TIMEOUT_C) begin
      counter_d   = TIMEOUT_C;
      warning_d   = 1'b1;
      triggered_d = 1'b1;
    end else begin
      counter_d = count_inc;
      warning_d = (count_inc >= WARNING_C);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      counter_q   <= '0;
      warning_q   <= 1'b0;
      triggered_q <= 1'b0;
    end else begin
      counter_q   <= counter_d;
      warning_q   <= warning_d;
      triggered_q <= triggered_d;
    end
  end

  assign counter   = counter_q;
  assign warning   = warning_q;
  assign triggered = triggered_q;

`ifdef FORMAL
  logic f_past_valid;

  // Marks that a past value exists for $past-based checks.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) f_past_valid <= 1'b0;
    else       f_past_valid <= 1'b1;
  end

  // Structural invariants of the watchdog state.
  always_comb begin
    if (rstn) begin
      assert (counter_q <= TIMEOUT_C);
      // A disable clears warning while the trigger stays latched, so the
      // implication only holds while the counter is non-zero.
      assert (!(triggered_q && counter_q != '0) || warning_q);
    end
  end

  // Past-value invariants: sticky trigger and disable clearing the counter.
  always @(posedge clk) begin
    if (f_past_valid && rstn && $past(rstn)) begin
      if ($past(triggered_q) && !$past(force_reset)) assert (triggered_q);
      if (!$past(enable)) assert (counter_q == '0);
    end
  end
`endif

endmodule : radio_watchdog_timer

// File: tb/tb_radio_watchdog_timer.sv
// Directed self-checking bench for radio_watchdog_timer with TIMEOUT=8, WARNING=6.
module tb_radio_watchdog_timer;

  logic        clk;
  logic        rstn;
  logic        enable;
  logic        heartbeat;
  logic        force_reset;
  logic [31:0] counter;
  logic        warning;
  logic        triggered;

  int checks;
  int errors;

  radio_watchdog_timer #(
    .TIMEOUT_CYCLES(64'd8),
    .WARNING_CYCLES(64'd6)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .enable     (enable),
    .heartbeat  (heartbeat),
    .force_reset(force_reset),
    .counter    (counter),
    .warning    (warning),
    .triggered  (triggered)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bring the DUT back to a zeroed, enabled state via force_reset.
  task automatic clear_dut();
    enable      = 1'b1;
    heartbeat   = 1'b0;
    force_reset = 1'b1;
    step();
    force_reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [33:0] exp;
    rstn        = 1'b0;
    enable      = 1'b0;
    heartbeat   = 1'b0;
    force_reset = 1'b0;
    step();
    step();
    checks++;
    if ({counter, warning, triggered} !== 34'd0) begin
      errors++;
      $display("FAIL reset_state: got cnt=%0d warn=%0b trig=%0b, want 0/0/0", counter, warning, triggered);
    end
    rstn   = 1'b1;
    enable = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp = {(k >= 8) ? 32'd8 : 32'(k), (k >= 6), (k >= 8)};
      checks++;
      if ({counter, warning, triggered} !== exp) begin
        errors++;
        $display("FAIL count_up k=%0d: got cnt=%0d warn=%0b trig=%0b, want cnt=%0d warn=%0b trig=%0b",
                 k, counter, warning, triggered, exp[33:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_sticky_trigger();
    // Entered with triggered=1, counter=8.
    heartbeat = 1'b1;
    step();
    checks++;
    if ({counter, warning, triggered} !== {32'd8, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sticky_heartbeat: got cnt=%0d warn=%0b trig=%0b, want 8/1/1", counter, warning, triggered);
    end
    heartbeat = 1'b0;
    enable    = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if ({counter, warning, triggered} !== {32'd0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL sticky_disabled %0d: got cnt=%0d warn=%0b trig=%0b, want 0/0/1", k, counter, warning, triggered);
      end
    end
    force_reset = 1'b1;
    step();
    force_reset = 1'b0;
    checks++;
    if ({counter, warning, triggered} !== 34'd0) begin
      errors++;
      $display("FAIL sticky_force_reset: got cnt=%0d warn=%0b trig=%0b, want 0/0/0", counter, warning, triggered);
    end
  endtask

  task automatic test_kick();
    clear_dut();
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (counter !== 32'd5) begin
      errors++;
      $display("FAIL kick_precount: got cnt=%0d, want 5", counter);
    end
    heartbeat = 1'b1;
    step();
    heartbeat = 1'b0;
    checks++;
    if ({counter, warning, triggered} !== 34'd0) begin
      errors++;
      $display("FAIL kick_clear: got cnt=%0d warn=%0b trig=%0b, want 0/0/0", counter, warning, triggered);
    end
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++;
      if ({counter, warning, triggered} !== {32'(k), (k >= 6), 1'b0}) begin
        errors++;
        $display("FAIL kick_recount k=%0d: got cnt=%0d warn=%0b trig=%0b, want cnt=%0d warn=%0b trig=0",
                 k, counter, warning, triggered, k, (k >= 6));
      end
    end
  endtask

  task automatic test_race();
    // Entered with counter=7: a heartbeat here beats the would-be timeout.
    heartbeat = 1'b1;
    step();
    heartbeat = 1'b0;
    checks++;
    if ({counter, warning, triggered} !== 34'd0) begin
      errors++;
      $display("FAIL race_heartbeat: got cnt=%0d warn=%0b trig=%0b, want 0/0/0", counter, warning, triggered);
    end
    step();
    checks++;
    if ({counter, warning, triggered} !== {32'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL race_after: got cnt=%0d warn=%0b trig=%0b, want 1/0/0", counter, warning, triggered);
    end
  endtask

  task automatic test_disable_mid_count();
    clear_dut();
    for (int k = 0; k < 6; k++) step();
    checks++;
    if ({counter, warning, triggered} !== {32'd6, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL disable_precount: got cnt=%0d warn=%0b trig=%0b, want 6/1/0", counter, warning, triggered);
    end
    enable = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if ({counter, warning, triggered} !== 34'd0) begin
        errors++;
        $display("FAIL disable_hold %0d: got cnt=%0d warn=%0b trig=%0b, want 0/0/0", k, counter, warning, triggered);
      end
    end
    enable = 1'b1;
    step();
    checks++;
    if ({counter, warning, triggered} !== {32'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL disable_restart: got cnt=%0d warn=%0b trig=%0b, want 1/0/0", counter, warning, triggered);
    end
  endtask

  task automatic test_async_reset();
    clear_dut();
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (counter !== 32'd4) begin
      errors++;
      $display("FAIL async_precount: got cnt=%0d, want 4", counter);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({counter, warning, triggered} !== 34'd0) begin
      errors++;
      $display("FAIL async_immediate: got cnt=%0d warn=%0b trig=%0b, want 0/0/0", counter, warning, triggered);
    end
    step();
    checks++;
    if ({counter, warning, triggered} !== 34'd0) begin
      errors++;
      $display("FAIL async_held: got cnt=%0d warn=%0b trig=%0b, want 0/0/0", counter, warning, triggered);
    end
    rstn = 1'b1;
    step();
    checks++;
    if ({counter, warning, triggered} !== {32'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_resume: got cnt=%0d warn=%0b trig=%0b, want 1/0/0", counter, warning, triggered);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sticky_trigger();
    test_kick();
    test_race();
    test_disable_mid_count();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule : tb_radio_watchdog_timer
